// File: rtl/stack_dmem_mp_pkg.sv
// -----------------------------------------------------------------------------
// stack_dmem_mp_pkg
// Shared configuration for the multi-port stack data memory.
//   - Default word-address width / depth. The STACK_ADDRW and STACK_ENTRIES
//     defines are normally supplied by the platform define include. The
//     fallbacks below apply when that include is absent.
//   - clog2 helper used to derive bank / row / port index widths.
//   - Byte-strobe merge helper shared by the bank model.
// Optional feature macro (used by stack_dmem_mp): STACK_DMEM_BOUNDS_EN
// -----------------------------------------------------------------------------
`ifndef STACK_ADDRW
`define STACK_ADDRW 8
`endif
`ifndef STACK_ENTRIES
`define STACK_ENTRIES 256
`endif

package stack_dmem_mp_pkg;

    localparam int STACK_ADDRW_DEF   = `STACK_ADDRW;
    localparam int STACK_ENTRIES_DEF = `STACK_ENTRIES;
    localparam int WORD_W            = 32;
    localparam int STRB_W            = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Replace only the bytes of old_word whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stack_dmem_bank.sv
// -----------------------------------------------------------------------------
// stack_dmem_bank
// One block-RAM bank: single read/write port, byte-strobed writes,
// registered read data (valid the cycle after re_i).
// Ports:
//   clk_i    clock
//   re_i     read enable (captures word at addr_i into rdata_o)
//   we_i     write enable (bytes selected by wstrb_i)
//   addr_i   row address within the bank
//   wdata_i  write data
//   wstrb_i  byte strobes
//   rdata_o  registered read data; holds when re_i is low
// -----------------------------------------------------------------------------
module stack_dmem_bank
    import stack_dmem_mp_pkg::*;
#(
    parameter int AW    = 7,
    parameter int DEPTH = 128
)(
    input  logic          clk_i,
    input  logic          re_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    wstrb_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] r_mem [DEPTH];

    // Memory array and output register; no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[addr_i] <= merge_bytes(r_mem[addr_i], wdata_i, wstrb_i);
        end
        if (re_i) begin
            rdata_o <= r_mem[addr_i];
        end
    end

endmodule

// File: rtl/stack_dmem_mp.sv
// -----------------------------------------------------------------------------
// stack_dmem_mp
// Multi-port, word-interleaved stack data memory. NCORES request ports share
// NBANKS banks; each bank has its own round-robin arbiter. Grants are
// combinational; read data returns one cycle after the grant.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   req_i     per-port request valid
//   we_i      per-port write(1)/read(0)
//   addr_i    per-port word address, port p at [p*STACK_ADDRW +: STACK_ADDRW]
//   wdata_i   per-port write data (32 bits each)
//   wstrb_i   per-port byte strobes (4 bits each)
//   gnt_o     per-port grant, same cycle as the request
//   rvalid_o  per-port read-data valid, one cycle after a granted read
//   rdata_o   per-port read data; holds until the next granted read
//   err_o     per-port access fault pulse (bounds checking only)
// Optional feature macro: STACK_DMEM_BOUNDS_EN
//   Each port is confined to its own slice of STACK_ENTRIES/NCORES words.
//   Out-of-range accesses are granted, writes are dropped, reads return 0,
//   and err_o pulses one cycle after the grant. Without it err_o is 0.
// -----------------------------------------------------------------------------
module stack_dmem_mp
    import stack_dmem_mp_pkg::*;
#(
    parameter int NCORES        = 4,
    parameter int NBANKS        = 2,
    parameter int STACK_ADDRW   = STACK_ADDRW_DEF,
    parameter int STACK_ENTRIES = STACK_ENTRIES_DEF
)(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NCORES-1:0]             req_i,
    input  logic [NCORES-1:0]             we_i,
    input  logic [NCORES*STACK_ADDRW-1:0] addr_i,
    input  logic [NCORES*32-1:0]          wdata_i,
    input  logic [NCORES*4-1:0]           wstrb_i,
    output logic [NCORES-1:0]             gnt_o,
    output logic [NCORES-1:0]             rvalid_o,
    output logic [NCORES*32-1:0]          rdata_o,
    output logic [NCORES-1:0]             err_o
);

    localparam int BANKW      = clog2(NBANKS);
    localparam int ROWW       = STACK_ADDRW - BANKW;
    localparam int ROWW_P     = (ROWW > 0) ? ROWW : 1;
    localparam int BANKW_P    = (BANKW > 0) ? BANKW : 1;
    localparam int PORTW      = (NCORES > 1) ? clog2(NCORES) : 1;
    localparam int SLICE      = STACK_ENTRIES / NCORES;
    localparam int BANK_DEPTH = STACK_ENTRIES / NBANKS;

    // Per-port address decode
    logic [STACK_ADDRW-1:0] w_addr [NCORES];
    logic [BANKW_P-1:0]     w_bank [NCORES];
    logic [ROWW_P-1:0]      w_row  [NCORES];
    logic [NCORES-1:0]      w_in_range;

    for (genvar p = 0; p < NCORES; p++) begin : g_port
        assign w_addr[p] = addr_i[p*STACK_ADDRW +: STACK_ADDRW];
        // Low address bits select the bank, the rest select the row.
        assign w_bank[p] = BANKW_P'(w_addr[p] & STACK_ADDRW'(NBANKS - 1));
        assign w_row[p]  = ROWW_P'(w_addr[p] >> BANKW);
`ifdef STACK_DMEM_BOUNDS_EN
        localparam logic [31:0] SLICE_LO = 32'(p * SLICE);
        localparam logic [31:0] SLICE_HI = 32'((p + 1) * SLICE);
        assign w_in_range[p] = (32'(w_addr[p]) >= SLICE_LO) &&
                               (32'(w_addr[p]) <  SLICE_HI);
`else
        assign w_in_range[p] = 1'b1;
`endif
    end

    // Arbitration state and results
    logic [PORTW-1:0]  r_rr_ptr   [NBANKS];
    logic [NBANKS-1:0] w_bank_vld;
    logic [PORTW-1:0]  w_bank_win [NBANKS];
    logic [NCORES-1:0] w_gnt;

    // Bank interface
    logic [NBANKS-1:0] w_bk_re;
    logic [NBANKS-1:0] w_bk_we;
    logic [ROWW_P-1:0] w_bk_addr  [NBANKS];
    logic [31:0]       w_bk_wdata [NBANKS];
    logic [3:0]        w_bk_wstrb [NBANKS];
    logic [31:0]       w_bk_rdata [NBANKS];

    // Response tracking
    logic [NBANKS-1:0]             r_bank_rd;
    logic [PORTW-1:0]              r_bank_id [NBANKS];
    logic [NCORES-1:0]             r_rvalid;
    logic [NCORES-1:0][31:0]       r_rdata_hold;
    logic [NCORES-1:0][31:0]       w_rdata;

    // Per-bank round-robin search: first requester at or after the pointer.
    always_comb begin : arb_comb
        int cand;
        cand = 0;
        for (int b = 0; b < NBANKS; b++) begin
            w_bank_vld[b] = 1'b0;
            w_bank_win[b] = {PORTW{1'b0}};
            for (int k = 0; k < NCORES; k++) begin
                cand = (int'(r_rr_ptr[b]) + k) % NCORES;
                if (!w_bank_vld[b] && !rst_i && req_i[cand] &&
                    (int'(w_bank[cand]) == b)) begin
                    w_bank_vld[b] = 1'b1;
                    w_bank_win[b] = PORTW'(cand);
                end else begin
                    w_bank_vld[b] = w_bank_vld[b];
                end
            end
        end
    end

    // Fold the per-bank winners into the per-port grant vector.
    always_comb begin
        w_gnt = {NCORES{1'b0}};
        for (int b = 0; b < NBANKS; b++) begin
            if (w_bank_vld[b]) begin
                w_gnt[w_bank_win[b]] = 1'b1;
            end else begin
                w_gnt = w_gnt;
            end
        end
    end

    assign gnt_o = w_gnt;

    // Steer the winning port's request onto its bank. Out-of-range accesses
    // never touch the array.
    always_comb begin
        for (int b = 0; b < NBANKS; b++) begin
            w_bk_re[b]    = w_bank_vld[b] && !we_i[w_bank_win[b]] && w_in_range[w_bank_win[b]];
            w_bk_we[b]    = w_bank_vld[b] &&  we_i[w_bank_win[b]] && w_in_range[w_bank_win[b]];
            w_bk_addr[b]  = w_row[w_bank_win[b]];
            w_bk_wdata[b] = wdata_i[int'(w_bank_win[b]) * 32 +: 32];
            w_bk_wstrb[b] = wstrb_i[int'(w_bank_win[b]) * 4 +: 4];
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        stack_dmem_bank #(
            .AW    (ROWW_P),
            .DEPTH (BANK_DEPTH)
        ) u_bank (
            .clk_i   (clk_i),
            .re_i    (w_bk_re[b]),
            .we_i    (w_bk_we[b]),
            .addr_i  (w_bk_addr[b]),
            .wdata_i (w_bk_wdata[b]),
            .wstrb_i (w_bk_wstrb[b]),
            .rdata_o (w_bk_rdata[b])
        );
    end

    // Round-robin pointers advance past the winner; hold when idle.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NBANKS; b++) begin
            if (rst_i) begin
                r_rr_ptr[b] <= {PORTW{1'b0}};
            end else if (w_bank_vld[b]) begin
                r_rr_ptr[b] <= PORTW'((int'(w_bank_win[b]) + 1) % NCORES);
            end else begin
                r_rr_ptr[b] <= r_rr_ptr[b];
            end
        end
    end

    // Remember which port each bank served so its data can be routed back.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bank_rd <= {NBANKS{1'b0}};
            r_rvalid  <= {NCORES{1'b0}};
            for (int b = 0; b < NBANKS; b++) begin
                r_bank_id[b] <= {PORTW{1'b0}};
            end
        end else begin
            r_bank_rd <= w_bk_re;
            r_rvalid  <= w_gnt & ~we_i;
            for (int b = 0; b < NBANKS; b++) begin
                r_bank_id[b] <= w_bank_win[b];
            end
        end
    end

    // Read data: fresh bank output for in-range reads, zero for faulted
    // reads, otherwise the port's held value.
    always_comb begin
        w_rdata = r_rdata_hold;
        for (int p = 0; p < NCORES; p++) begin
            if (r_rvalid[p]) begin
                w_rdata[p] = 32'h0000_0000;
            end else begin
                w_rdata[p] = w_rdata[p];
            end
        end
        for (int b = 0; b < NBANKS; b++) begin
            if (r_bank_rd[b]) begin
                w_rdata[r_bank_id[b]] = w_bk_rdata[b];
            end else begin
                w_rdata = w_rdata;
            end
        end
        if (rst_i) begin
            w_rdata = {NCORES{32'h0000_0000}};
        end else begin
            w_rdata = w_rdata;
        end
    end

    // Per-port data register so each port keeps its last read result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata_hold <= {NCORES{32'h0000_0000}};
        end else begin
            r_rdata_hold <= w_rdata;
        end
    end

    assign rdata_o  = w_rdata;
    // A response registered just before reset is suppressed while reset is high.
    assign rvalid_o = r_rvalid & ~{NCORES{rst_i}};

`ifdef STACK_DMEM_BOUNDS_EN
    logic [NCORES-1:0] r_err;

    // Fault pulse one cycle after an out-of-range grant (read or write).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= {NCORES{1'b0}};
        end else begin
            r_err <= w_gnt & ~w_in_range;
        end
    end

    assign err_o = r_err & ~{NCORES{rst_i}};
`else
    assign err_o = {NCORES{1'b0}};
`endif

endmodule

// File: tb/tb_stack_dmem_mp.sv
// -----------------------------------------------------------------------------
// tb_stack_dmem_mp
// Directed stimulus with a response scoreboard for stack_dmem_mp
// (NCORES=4, NBANKS=2). Each cycle the expected grant vector is supplied by
// the stimulus; granted reads/faults push their expected response, which is
// popped and compared in the following cycle.
// -----------------------------------------------------------------------------
module tb_stack_dmem_mp;
    import stack_dmem_mp_pkg::*;

    localparam int NC   = 4;
    localparam int NB   = 2;
    localparam int AW   = STACK_ADDRW_DEF;
    localparam int NE   = STACK_ENTRIES_DEF;
    localparam int SLC  = NE / NC;

    logic               clk = 1'b0;
    logic               rst_v;
    logic [NC-1:0]      req_v;
    logic [NC-1:0]      we_v;
    logic [NC*AW-1:0]   addr_v;
    logic [NC*32-1:0]   wdata_v;
    logic [NC*4-1:0]    wstrb_v;
    logic [NC-1:0]      gnt_o;
    logic [NC-1:0]      rvalid_o;
    logic [NC*32-1:0]   rdata_o;
    logic [NC-1:0]      err_o;

    stack_dmem_mp #(
        .NCORES        (NC),
        .NBANKS        (NB),
        .STACK_ADDRW   (AW),
        .STACK_ENTRIES (NE)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_v),
        .req_i    (req_v),
        .we_i     (we_v),
        .addr_i   (addr_v),
        .wdata_i  (wdata_v),
        .wstrb_i  (wstrb_v),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        bit          is_rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] mem_m   [NE];
    logic [31:0] last_rd [NC];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input int p, input int a);
`ifdef STACK_DMEM_BOUNDS_EN
        return (a >= p * SLC) && (a < (p + 1) * SLC);
`else
        return (p >= 0) && (a >= 0);
`endif
    endfunction

    task automatic idle_all();
        req_v   = '0;
        we_v    = '0;
        addr_v  = '0;
        wdata_v = '0;
        wstrb_v = '0;
    endtask

    task automatic set_port(input int p, input bit we, input int a,
                            input logic [31:0] d, input logic [3:0] s);
        req_v[p]             = 1'b1;
        we_v[p]              = we;
        addr_v[p*AW +: AW]   = AW'(a);
        wdata_v[p*32 +: 32]  = d;
        wstrb_v[p*4 +: 4]    = s;
    endtask

    // One clock cycle: check responses due now and the grant vector, then
    // record expectations for this cycle's grants and advance the clock.
    task automatic step(input logic [NC-1:0] exp_gnt);
        logic [NC-1:0] exp_rv;
        logic [NC-1:0] exp_err;
        logic [31:0]   exp_d [NC];
        exp_t          e;
        int            a;
        #1;
        exp_rv  = '0;
        exp_err = '0;
        for (int p = 0; p < NC; p++) exp_d[p] = last_rd[p];
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.is_rd) begin
                exp_rv[e.port] = 1'b1;
                exp_d[e.port]  = e.data;
            end
            if (e.err) exp_err[e.port] = 1'b1;
        end
        if (rst_v) begin
            exp_rv  = '0;
            exp_err = '0;
            for (int p = 0; p < NC; p++) exp_d[p] = 32'h0;
        end
        check_eq("rvalid", 32'(rvalid_o), 32'(exp_rv));
        check_eq("err", 32'(err_o), 32'(exp_err));
        for (int p = 0; p < NC; p++) begin
            check_eq($sformatf("rdata%0d", p), rdata_o[p*32 +: 32], exp_d[p]);
            last_rd[p] = exp_d[p];
        end
        check_eq("gnt", 32'(gnt_o), 32'(exp_gnt));
        if (!rst_v) begin
            // Reads first: they see memory before this cycle's writes.
            for (int p = 0; p < NC; p++) begin
                a = int'(addr_v[p*AW +: AW]);
                if (exp_gnt[p] && !we_v[p]) begin
                    if (in_range(p, a)) sb_q.push_back('{port: p, is_rd: 1'b1, data: mem_m[a], err: 1'b0});
                    else                sb_q.push_back('{port: p, is_rd: 1'b1, data: 32'h0, err: 1'b1});
                end
            end
            for (int p = 0; p < NC; p++) begin
                a = int'(addr_v[p*AW +: AW]);
                if (exp_gnt[p] && we_v[p]) begin
                    if (in_range(p, a)) mem_m[a] = merge_bytes(mem_m[a], wdata_v[p*32 +: 32], wstrb_v[p*4 +: 4]);
                    else                sb_q.push_back('{port: p, is_rd: 1'b0, data: 32'h0, err: 1'b1});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pre_addr [6];
        pre_addr = '{0, 2, 4, 6, 7, 10};
        for (int p = 0; p < NC; p++) last_rd[p] = 32'h0;

        // Reset with all ports requesting: no grants, outputs cleared.
        idle_all();
        rst_v = 1'b1;
        for (int p = 0; p < NC; p++) set_port(p, 1'b0, 0, 32'h0, 4'h0);
        step(4'b0000);
        step(4'b0000);
        rst_v = 1'b0;

        // Single port write then read-back.
        idle_all(); set_port(0, 1'b1, 5, 32'hDEAD_BEEF, 4'hF); step(4'b0001);
        idle_all(); set_port(0, 1'b0, 5, 32'h0, 4'h0);          step(4'b0001);

        // Byte strobes.
        idle_all(); set_port(0, 1'b1, 9, 32'h1122_3344, 4'hF);  step(4'b0001);
        idle_all(); set_port(0, 1'b1, 9, 32'hAABB_CCDD, 4'h5);  step(4'b0001);
        idle_all(); set_port(0, 1'b0, 9, 32'h0, 4'h0);          step(4'b0001);
        check_eq("strobe_model", mem_m[9], 32'h11BB_33DD);

        // Zero-strobe write: granted, no data change, no response.
        idle_all(); set_port(0, 1'b1, 9, 32'hFFFF_FFFF, 4'h0);  step(4'b0001);

        // Preload words used by later tests.
        for (int i = 0; i < 6; i++) begin
            idle_all();
            set_port(0, 1'b1, pre_addr[i], 32'hA000_0000 | 32'(pre_addr[i]), 4'hF);
            step(4'b0001);
        end

        // Reset to clear pointers, then four ports fight over bank 0.
        idle_all(); rst_v = 1'b1; step(4'b0000); rst_v = 1'b0;
        idle_all();
        for (int p = 0; p < NC; p++) set_port(p, 1'b0, 2 * p, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) step(4'(1 << (i % 4)));

        // Parallel: different banks granted together.
        idle_all(); set_port(0, 1'b0, 4, 32'h0, 4'h0); set_port(1, 1'b0, 7, 32'h0, 4'h0);
        step(4'b0011);

        // Bank 1 pointer at 2 wraps around to port 0, then port 1.
        idle_all(); set_port(0, 1'b0, 5, 32'h0, 4'h0); set_port(1, 1'b0, 7, 32'h0, 4'h0);
        step(4'b0001);
        idle_all(); set_port(1, 1'b0, 7, 32'h0, 4'h0);
        step(4'b0010);

        // Reset right after a granted read: response dropped.
        idle_all(); set_port(0, 1'b0, 5, 32'h0, 4'h0); step(4'b0001);
        idle_all(); rst_v = 1'b1; step(4'b0000); rst_v = 1'b0;

        // Bank 0 pointer is back at 0, so port 0 wins over port 2.
        idle_all(); set_port(0, 1'b0, 0, 32'h0, 4'h0); set_port(2, 1'b0, 4, 32'h0, 4'h0);
        step(4'b0001);
        idle_all(); set_port(2, 1'b0, 4, 32'h0, 4'h0);
        step(4'b0100);

        // Data written before reset survives.
        idle_all(); set_port(0, 1'b0, 5, 32'h0, 4'h0); step(4'b0001);

        // Partition behaviour (global access when bounds checking is off).
        idle_all(); set_port(1, 1'b1, 10, 32'h5555_5555, 4'hF); step(4'b0010);
        idle_all(); set_port(0, 1'b0, 10, 32'h0, 4'h0);         step(4'b0001);
        idle_all(); set_port(1, 1'b1, 70, 32'h7070_7070, 4'hF); step(4'b0010);
        idle_all(); set_port(1, 1'b0, 70, 32'h0, 4'h0);         step(4'b0010);

        // Drain and idle: rdata must hold.
        idle_all();
        step(4'b0000);
        step(4'b0000);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
